ready_sequencer: RTL and testbench

READY_SEQUENCER -- requirements
Module: ready_sequencer

---
 rtl/ready_seq_pkg.sv | 10 +
 rtl/ready_sequencer_sync_rise.sv | 38 +++
 rtl/ready_sequencer.sv | 135 +++++++++++++
 tb/tb_ready_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ready_seq_pkg.sv
// Shared types for the ready sequencer: FSM state encoding.
package ready_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_READY = 2'd2
  } state_t;

endpackage

// File: rtl/ready_sequencer_sync_rise.sv
// Two-flop synchroniser with a registered-history rising-edge detector.
// No edge is reported until the synchronised input has been seen low after reset.
module sync_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic r_s1;
  logic r_s2;
  logic r_s2_d;
  logic r_v1;
  logic r_v2;
  logic r_seen_low;

  // r_v1/r_v2 mark when r_s2 holds a real sample rather than its reset value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s2_d     <= 1'b0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_seen_low <= 1'b0;
    end else begin
      r_s1       <= d;
      r_s2       <= r_s1;
      r_s2_d     <= r_s2;
      r_v1       <= 1'b1;
      r_v2       <= r_v1;
      r_seen_low <= r_seen_low | (r_v2 & ~r_s2);
    end
  end

  assign rise = r_s2 & ~r_s2_d & r_seen_low;

endmodule

// File: rtl/ready_sequencer.sv
// Countdown sequencer: a button press arms a STEPS-lamp countdown ending in READY.
// Optional macro READY_SEQUENCER_BLINK_EN makes the lamps blink while READY.
//
// state    | meaning
// ST_IDLE  | waiting for a press, all outputs low
// ST_ARM   | counting down, lamps fill one per TICK_DIV cycles; press aborts
// ST_READY | countdown complete; press returns to idle
module ready_sequencer
  import ready_seq_pkg::*;
#(
  parameter int STEPS    = 4,
  parameter int TICK_DIV = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mc,
  output logic             ready,
  output logic             busy,
  output logic [STEPS-1:0] leds,
  output logic             false_start
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STEPS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TW-1:0]    r_tick;
  logic [TW-1:0]    w_tick_nxt;
  logic [SW-1:0]    r_step;
  logic [SW-1:0]    w_step_nxt;
  logic [STEPS-1:0] r_leds;
  logic [STEPS-1:0] w_leds_nxt;
  logic             r_ready;
  logic             r_busy;
  logic             r_false_start;
  logic             w_false_start_nxt;
  logic             w_rise;
  logic             w_tc;

  sync_rise u_sync_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (mc),
    .rise (w_rise)
  );

  function automatic logic [STEPS-1:0] therm(input logic [SW-1:0] n);
    therm = '0;
    for (int i = 0; i < STEPS; i++) therm[i] = (i < int'(n));
  endfunction

  assign w_tc = (r_tick == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_tick        <= '0;
      r_step        <= '0;
      r_leds        <= '0;
      r_ready       <= 1'b0;
      r_busy        <= 1'b0;
      r_false_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tick        <= w_tick_nxt;
      r_step        <= w_step_nxt;
      r_leds        <= w_leds_nxt;
      r_ready       <= (w_state_nxt == ST_READY);
      r_busy        <= (w_state_nxt == ST_ARM);
      r_false_start <= w_false_start_nxt;
    end
  end

  // Outputs are registered from next-state values so they change on the transition edge
  always_comb begin
    w_state_nxt       = r_state;
    w_tick_nxt        = r_tick;
    w_step_nxt        = r_step;
    w_leds_nxt        = '0;
    w_false_start_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tick_nxt = '0;
        w_step_nxt = '0;
        if (w_rise) w_state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (w_rise) begin
          w_state_nxt       = ST_IDLE;
          w_tick_nxt        = '0;
          w_step_nxt        = '0;
          w_false_start_nxt = 1'b1;
        end else begin
          if (w_tc) begin
            w_tick_nxt = '0;
            w_step_nxt = r_step + SW'(1);
            if (r_step == STEP_LAST) w_state_nxt = ST_READY;
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
          w_leds_nxt = therm(w_step_nxt);
        end
      end
      ST_READY: begin
        if (w_rise) begin
          w_state_nxt = ST_IDLE;
          w_tick_nxt  = '0;
          w_step_nxt  = '0;
        end else begin
`ifdef READY_SEQUENCER_BLINK_EN
          w_tick_nxt = w_tc ? '0 : r_tick + TW'(1);
          w_leds_nxt = w_tc ? ~r_leds : r_leds;
`else
          w_tick_nxt = '0;
          w_leds_nxt = '1;
`endif
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tick_nxt  = '0;
        w_step_nxt  = '0;
      end
    endcase
  end

  assign ready       = r_ready;
  assign busy        = r_busy;
  assign leds        = r_leds;
  assign false_start = r_false_start;

endmodule

// File: tb/tb_ready_sequencer.sv
// Directed self-checking bench for ready_sequencer with STEPS=3, TICK_DIV=4.
module tb_ready_sequencer;

  localparam int STEPS    = 3;
  localparam int TICK_DIV = 4;

`ifdef READY_SEQUENCER_BLINK_EN
  localparam logic [2:0] EXP_BLINK = 3'b000;
`else
  localparam logic [2:0] EXP_BLINK = 3'b111;
`endif

  logic       clk;
  logic       rst;
  logic       mc;
  logic       ready;
  logic       busy;
  logic [2:0] leds;
  logic       false_start;

  int n_cmp;
  int n_err;

  ready_sequencer #(
    .STEPS    (STEPS),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mc          (mc),
    .ready       (ready),
    .busy        (busy),
    .leds        (leds),
    .false_start (false_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic r, input logic b, input logic [2:0] l,
                           input logic f);
    check_eq({tag, ".ready"}, 32'(ready), 32'(r));
    check_eq({tag, ".busy"}, 32'(busy), 32'(b));
    check_eq({tag, ".leds"}, 32'(leds), 32'(l));
    check_eq({tag, ".false_start"}, 32'(false_start), 32'(f));
  endtask

  // mc high for two clock edges; the state reacts on the next edge after return
  task automatic press();
    mc = 1'b1;
    cyc(2);
    mc = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    mc    = 1'b0;
    cyc(3);
    check_out("reset", 1'b0, 1'b0, 3'b000, 1'b0);
    rst = 1'b0;
    cyc(3);
    check_out("idle", 1'b0, 1'b0, 3'b000, 1'b0);

    // full countdown
    press();
    check_eq("arm_pre.busy", 32'(busy), 32'd0);
    cyc(1);
    check_out("arm_entry", 1'b0, 1'b1, 3'b000, 1'b0);
    cyc(3);
    check_eq("arm_t3.leds", 32'(leds), 32'd0);
    cyc(1);
    check_out("arm_t4", 1'b0, 1'b1, 3'b001, 1'b0);
    cyc(4);
    check_out("arm_t8", 1'b0, 1'b1, 3'b011, 1'b0);
    cyc(3);
    check_out("arm_t11", 1'b0, 1'b1, 3'b011, 1'b0);
    cyc(1);
    check_out("ready_t12", 1'b1, 1'b0, 3'b111, 1'b0);

    // READY lamp behaviour
    cyc(4);
    check_out("ready_p4", 1'b1, 1'b0, EXP_BLINK, 1'b0);
    cyc(4);
    check_out("ready_p8", 1'b1, 1'b0, 3'b111, 1'b0);

    // press in READY returns to IDLE, second press restarts full countdown
    press();
    check_eq("ready_hold.ready", 32'(ready), 32'd1);
    cyc(1);
    check_out("ready_exit", 1'b0, 1'b0, 3'b000, 1'b0);
    press();
    cyc(1);
    check_out("rearm_entry", 1'b0, 1'b1, 3'b000, 1'b0);
    cyc(11);
    check_out("rearm_t11", 1'b0, 1'b1, 3'b011, 1'b0);
    cyc(1);
    check_out("rearm_t12", 1'b1, 1'b0, 3'b111, 1'b0);
    press();
    cyc(1);
    check_out("rearm_exit", 1'b0, 1'b0, 3'b000, 1'b0);

    // abort after two lamps
    press();
    cyc(1);
    cyc(8);
    check_out("abort_t8", 1'b0, 1'b1, 3'b011, 1'b0);
    press();
    check_out("abort_pre", 1'b0, 1'b1, 3'b011, 1'b0);
    cyc(1);
    check_out("abort_edge", 1'b0, 1'b0, 3'b000, 1'b1);
    cyc(1);
    check_out("abort_after", 1'b0, 1'b0, 3'b000, 1'b0);
    cyc(3);
    check_out("abort_settle", 1'b0, 1'b0, 3'b000, 1'b0);

    // abort coinciding with the final terminal count
    press();
    cyc(1);
    check_eq("race_entry.busy", 32'(busy), 32'd1);
    cyc(9);
    press();
    check_out("race_pre", 1'b0, 1'b1, 3'b011, 1'b0);
    cyc(1);
    check_out("race_edge", 1'b0, 1'b0, 3'b000, 1'b1);
    cyc(1);
    check_out("race_after", 1'b0, 1'b0, 3'b000, 1'b0);

    // asynchronous reset mid-ARM, mc held high through release
    cyc(2);
    press();
    cyc(1);
    cyc(4);
    check_out("rst_arm_t4", 1'b0, 1'b1, 3'b001, 1'b0);
    #2;
    rst = 1'b1;
    mc  = 1'b1;
    #1;
    check_out("rst_async", 1'b0, 1'b0, 3'b000, 1'b0);
    cyc(3);
    rst = 1'b0;
    cyc(6);
    check_out("rst_mc_high", 1'b0, 1'b0, 3'b000, 1'b0);
    mc = 1'b0;
    cyc(3);
    check_eq("rst_mc_low.busy", 32'(busy), 32'd0);
    press();
    check_eq("rst_repress_pre.busy", 32'(busy), 32'd0);
    cyc(1);
    check_out("rst_repress", 1'b0, 1'b1, 3'b000, 1'b0);
    cyc(4);
    check_eq("rst_repress_t4.leds", 32'(leds), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
